// File: rtl/axis_read_addr_if.sv
// Handshake bundle for axis_read_addr: config request, read-length hand-off to the
// read-data unpacker, the AXI AR channel, and a monitor-only tap of the R channel.
//   master : the address generator (drives cfg_ready, rd_*, axi_ar{addr,len,valid})
//   slave  : the surrounding system (drives cfg_*, rd_ready, axi_arready, axi_r*)
interface axis_read_addr_if #(
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32
);
  logic [CFG_DWIDTH-1:0]     cfg_address;
  logic [CFG_DWIDTH-1:0]     cfg_length;
  logic                      cfg_valid;
  logic                      cfg_ready;

  logic [CFG_DWIDTH-1:0]     rd_length;
  logic                      rd_valid;
  logic                      rd_ready;

  logic [AXI_ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]                axi_arlen;
  logic                      axi_arvalid;
  logic                      axi_arready;

  logic                      axi_rvalid;
  logic                      axi_rready;
  logic                      axi_rlast;

  modport master (
    input  cfg_address, cfg_length, cfg_valid,
    output cfg_ready,
    output rd_length, rd_valid,
    input  rd_ready,
    output axi_araddr, axi_arlen, axi_arvalid,
    input  axi_arready,
    input  axi_rvalid, axi_rready, axi_rlast
  );

  modport slave (
    output cfg_address, cfg_length, cfg_valid,
    input  cfg_ready,
    input  rd_length, rd_valid,
    output rd_ready,
    input  axi_araddr, axi_arlen, axi_arvalid,
    output axi_arready,
    output axi_rvalid, axi_rready, axi_rlast
  );
endinterface

// File: rtl/axis_read_addr.sv
// AXI read-address generator. Accepts a (byte address, stream-word length) request,
// hands the length to the read-data unpacker, then splits the transfer into AXI
// bursts of at most BURST_MAX beats while keeping at most OUTSTANDING bursts in flight.
// Burst completion is observed on the R channel (rvalid & rready & rlast).
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus_io : axis_read_addr_if.master (cfg_*, rd_*, axi_ar*, axi_r* monitor)
//
// Build option: define AXIS_READ_4K_SPLIT_EN to additionally keep every burst inside
// one 4 KB page.
module axis_read_addr #(
  parameter int unsigned CFG_DWIDTH     = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 256,
  parameter int unsigned WIDTH_RATIO    = 8,
  parameter int unsigned BURST_MAX      = 16,
  parameter int unsigned OUTSTANDING    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  axis_read_addr_if.master bus_io
);

  localparam int unsigned BPB       = AXI_DATA_WIDTH / 8;
  localparam int unsigned OffBits   = $clog2(BPB);
  localparam int unsigned InflightW = $clog2(OUTSTANDING + 1);

  localparam logic [AXI_ADDR_WIDTH-1:0] LowMask  = AXI_ADDR_WIDTH'(BPB - 1);
  localparam logic [CFG_DWIDTH-1:0]     RatioC   = CFG_DWIDTH'(WIDTH_RATIO);
  localparam logic [CFG_DWIDTH-1:0]     BurstC   = CFG_DWIDTH'(BURST_MAX);
  localparam logic [InflightW-1:0]      MaxInfl  = InflightW'(OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StConfig, StAddr, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CFG_DWIDTH-1:0]     remaining_q, remaining_d;
  logic [CFG_DWIDTH-1:0]     length_q, length_d;
  logic [InflightW-1:0]      inflight_q, inflight_d;
  // Low during reset so cfg_ready stays 0; set on the first edge after release.
  logic                      alive_q;

  logic                      cfg_ready;
  logic                      rd_valid;
  logic                      ar_valid;
  logic                      ar_fire;
  logic                      r_done;
  logic                      partial;
  logic [CFG_DWIDTH-1:0]     cfg_beats;
  logic [8:0]                burst_n;

  // beats = ceil(length / WIDTH_RATIO), written so it cannot overflow.
  assign partial   = (bus_io.cfg_length % RatioC) != '0;
  assign cfg_beats = (bus_io.cfg_length / RatioC) + CFG_DWIDTH'(partial);

`ifdef AXIS_READ_4K_SPLIT_EN
  logic [12:0] page_left;
  logic [12:0] page_beats;
  assign page_left  = 13'd4096 - {1'b0, addr_q[11:0]};
  assign page_beats = page_left / 13'(BPB);
`endif

  always_comb begin
    burst_n = (remaining_q < BurstC) ? 9'(remaining_q) : 9'(BURST_MAX);
`ifdef AXIS_READ_4K_SPLIT_EN
    if (page_beats < 13'(burst_n)) begin
      burst_n = 9'(page_beats);
    end
`endif
  end

  assign ar_fire = ar_valid & bus_io.axi_arready;
  // Late rlast with nothing in flight is dropped to avoid underflow.
  assign r_done  = bus_io.axi_rvalid & bus_io.axi_rready & bus_io.axi_rlast &
                   (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q + InflightW'(ar_fire) - InflightW'(r_done);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    length_d    = length_q;
    cfg_ready   = 1'b0;
    rd_valid    = 1'b0;
    ar_valid    = 1'b0;
    case (state_q)
      StIdle: begin
        cfg_ready = alive_q;
        if (alive_q && bus_io.cfg_valid) begin
          addr_d      = AXI_ADDR_WIDTH'(bus_io.cfg_address) & ~LowMask;
          length_d    = bus_io.cfg_length;
          remaining_d = cfg_beats;
          if (bus_io.cfg_length != '0) begin
            state_d = StConfig;
          end
        end
      end
      StConfig: begin
        rd_valid = 1'b1;
        if (bus_io.rd_ready) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        // Only inflight can change while stalled, and only downward, so the
        // AR payload (addr_q, burst_n) holds until accepted.
        ar_valid = (remaining_q != '0) && (inflight_q < MaxInfl);
        if (ar_fire) begin
          addr_d      = addr_q + (AXI_ADDR_WIDTH'(burst_n) << OffBits);
          remaining_d = remaining_q - CFG_DWIDTH'(burst_n);
          if (remaining_q == CFG_DWIDTH'(burst_n)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (inflight_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      length_q    <= '0;
      inflight_q  <= '0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      length_q    <= length_d;
      inflight_q  <= inflight_d;
      alive_q     <= 1'b1;
    end
  end

  assign bus_io.cfg_ready   = cfg_ready;
  assign bus_io.rd_valid    = rd_valid;
  assign bus_io.rd_length   = length_q;
  assign bus_io.axi_arvalid = ar_valid;
  assign bus_io.axi_araddr  = addr_q;
  assign bus_io.axi_arlen   = ar_valid ? 8'(burst_n - 9'd1) : 8'd0;

endmodule

// File: tb/tb_axis_read_addr.sv
// Directed bench for axis_read_addr: expected rd lengths and AR bursts are queued
// when each request is issued and compared as the DUT presents them.
module tb_axis_read_addr;

  localparam int unsigned Bpb      = 32;
  localparam int unsigned Wr       = 8;
  localparam int unsigned BurstMax = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axis_read_addr_if bus ();

  axis_read_addr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         ar_q[$];
  logic [31:0] rd_q[$];

  int checks      = 0;
  int errors      = 0;
  int ar_count    = 0;
  int outstanding = 0;
  int base        = 0;
  bit auto_r       = 1'b0;
  bit rand_ready   = 1'b0;
  bit cfg_accepted = 1'b0;
  bit rd_seen      = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference burst split for one request.
  task automatic expect_req(input logic [31:0] addr, input logic [31:0] len);
    int unsigned rem;
    int unsigned n;
    logic [31:0] a;
    if (len == 0) return;
    rd_q.push_back(len);
    rd_seen = 1'b0;
    rem = (len + Wr - 1) / Wr;
    a   = addr & ~(Bpb - 1);
    while (rem > 0) begin
      n = (rem < BurstMax) ? rem : BurstMax;
`ifdef AXIS_READ_4K_SPLIT_EN
      if ((4096 - (a % 4096)) / Bpb < n) n = (4096 - (a % 4096)) / Bpb;
`endif
      ar_q.push_back('{addr: a, len: 8'(n - 1)});
      a   = a + n * Bpb;
      rem = rem - n;
    end
  endtask

  task automatic sample();
    if (bus.cfg_valid && bus.cfg_ready) cfg_accepted = 1'b1;
    if (rd_q.size() == 0) begin
      check("rd_valid_idle", bus.rd_valid, 0);
    end else if (bus.rd_valid && bus.rd_ready) begin
      check("rd_length", bus.rd_length, rd_q.pop_front());
      rd_seen = 1'b1;
    end
    if (bus.axi_rvalid && bus.axi_rready && bus.axi_rlast && outstanding > 0) outstanding--;
    if (ar_q.size() == 0) begin
      check("arvalid_idle", bus.axi_arvalid, 0);
    end else if (bus.axi_arvalid) begin
      check("araddr", bus.axi_araddr, ar_q[0].addr);
      check("arlen", bus.axi_arlen, ar_q[0].len);
      if (bus.axi_arready) begin
        check("rd_before_ar", rd_seen, 1);
        ar_q.delete(0);
        ar_count++;
        outstanding++;
      end
    end
  endtask

  // Sample on the falling edge, drive 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (cfg_accepted) bus.cfg_valid = 1'b0;
    if (rand_ready) begin
      bus.axi_arready = 1'($urandom_range(0, 1));
      bus.rd_ready    = 1'($urandom_range(0, 1));
    end
    if (auto_r) begin
      bus.axi_rvalid = (outstanding > 0);
      bus.axi_rready = (outstanding > 0);
      bus.axi_rlast  = (outstanding > 0);
    end
  endtask

  task automatic send_cfg(input logic [31:0] addr, input logic [31:0] len);
    int i = 0;
    expect_req(addr, len);
    bus.cfg_address = addr;
    bus.cfg_length  = len;
    bus.cfg_valid   = 1'b1;
    cfg_accepted    = 1'b0;
    while (!cfg_accepted && i < 50) begin
      tick();
      i++;
    end
    check("cfg_accepted", cfg_accepted, 1);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (i < budget && !(bus.cfg_ready && ar_q.size() == 0 && rd_q.size() == 0)) begin
      tick();
      i++;
    end
    check("ar_drained", ar_q.size(), 0);
    check("back_to_idle", bus.cfg_ready, 1);
  endtask

  initial begin
    bus.cfg_address = '0;
    bus.cfg_length  = '0;
    bus.cfg_valid   = 1'b0;
    bus.rd_ready    = 1'b1;
    bus.axi_arready = 1'b1;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rready  = 1'b0;
    bus.axi_rlast   = 1'b0;

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_length", bus.rd_length, 0);
    check("rst_arvalid", bus.axi_arvalid, 0);
    check("rst_araddr", bus.axi_araddr, 0);
    check("rst_arlen", bus.axi_arlen, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("cfg_ready_after_reset", bus.cfg_ready, 1);

    // Short request: two beats in one burst
    auto_r = 1'b1;
    base   = ar_count;
    send_cfg(32'h0000_1000, 32'd10);
    wait_idle(100);
    check("short_ar_count", ar_count - base, 1);

    // 512 beats -> 32 full bursts
    base = ar_count;
    send_cfg(32'h0000_0000, 32'd4092);
    wait_idle(2000);
    check("long_ar_count", ar_count - base, 32);

    // Burst straddling a 4 KB page
    base = ar_count;
    send_cfg(32'h0000_0F80, 32'd64);
    wait_idle(200);
`ifdef AXIS_READ_4K_SPLIT_EN
    check("page_ar_count", ar_count - base, 2);
`else
    check("page_ar_count", ar_count - base, 1);
`endif

    // Outstanding limit: no R traffic caps issue at 4, one rlast frees one slot
    auto_r = 1'b0;
    base   = ar_count;
    send_cfg(32'h0000_0000, 32'd4092);
    repeat (30) tick();
    check("limit_ar_count", ar_count - base, 4);
    check("limit_arvalid", bus.axi_arvalid, 0);
    bus.axi_rvalid = 1'b1;
    bus.axi_rready = 1'b1;
    bus.axi_rlast  = 1'b1;
    tick();
    bus.axi_rvalid = 1'b0;
    bus.axi_rready = 1'b0;
    bus.axi_rlast  = 1'b0;
    repeat (20) tick();
    check("one_more_ar_count", ar_count - base, 5);
    check("refill_arvalid", bus.axi_arvalid, 0);
    auto_r = 1'b1;
    wait_idle(3000);

    // Random back-pressure on rd_ready and arready
    rand_ready = 1'b1;
    base       = ar_count;
    send_cfg(32'h0000_2000, 32'd300);
    wait_idle(3000);
    check("bp_ar_count", ar_count - base, 3);
    rand_ready      = 1'b0;
    bus.axi_arready = 1'b1;
    bus.rd_ready    = 1'b1;

    // Zero length: accepted, no rd, no AR
    send_cfg(32'h0000_0040, 32'd0);
    check("zero_cfg_ready", bus.cfg_ready, 1);
    check("zero_rd_valid", bus.rd_valid, 0);
    check("zero_arvalid", bus.axi_arvalid, 0);
    repeat (3) tick();

    // Reset in the middle of address issue
    auto_r = 1'b0;
    base   = ar_count;
    send_cfg(32'h0000_0000, 32'd4092);
    for (int i = 0; i < 50 && (ar_count - base) < 2; i++) tick();
    check("pre_reset_arvalid", bus.axi_arvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_arvalid", bus.axi_arvalid, 0);
    check("mid_rst_cfg_ready", bus.cfg_ready, 0);
    check("mid_rst_arlen", bus.axi_arlen, 0);
    ar_q.delete();
    rd_q.delete();
    outstanding    = 0;
    bus.axi_rvalid = 1'b0;
    bus.axi_rready = 1'b0;
    bus.axi_rlast  = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_cfg_ready", bus.cfg_ready, 1);
    auto_r = 1'b1;
    base   = ar_count;
    send_cfg(32'h0000_3000, 32'd24);
    wait_idle(100);
    check("post_rst_ar_count", ar_count - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_read_addr.md
AXIS_READ_ADDR -- requirements
Module: axis_read_addr

Interface
REQ-001 Parameter CFG_DWIDTH, default 32, is the width of the config address and length fields.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32, is the AXI read address width.
REQ-003 Parameter AXI_DATA_WIDTH, default 256, is the AXI beat width in bits; BPB = AXI_DATA_WIDTH/8 bytes per beat.
REQ-004 Parameter WIDTH_RATIO, default 8, is the number of stream words per AXI beat.
REQ-005 Parameter BURST_MAX, default 16, is the maximum number of beats per burst (1..256).
REQ-006 Parameter OUTSTANDING, default 4, is the maximum number of bursts in flight.
REQ-007 Port clk, input, 1 bit: the only clock.
REQ-008 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 Ports cfg_address, cfg_length, cfg_valid, cfg_ready: input CFG_DWIDTH, input CFG_DWIDTH, input 1, output 1; start byte address and length in stream words.
REQ-010 Ports rd_length, rd_valid, rd_ready: output CFG_DWIDTH, output 1, input 1; length handed to the read-data unpacker.
REQ-011 Ports axi_araddr, axi_arlen, axi_arvalid, axi_arready: output AXI_ADDR_WIDTH, output 8, output 1, input 1; AXI AR channel.
REQ-012 Ports axi_rvalid, axi_rready, axi_rlast: input 1, input 1, input 1; R channel monitor only, never driven.

Function
REQ-013 The FSM SHALL have four states: IDLE, CONFIG, ADDR, DRAIN.
REQ-014 IDLE: cfg_ready=1; on cfg_valid&cfg_ready, latch the address, latch beats = ceil(cfg_length/WIDTH_RATIO), and go to CONFIG (or stay in IDLE if cfg_length==0).
REQ-015 CONFIG: rd_valid=1 and rd_length = the latched cfg_length; on rd_ready, go to ADDR.
REQ-016 ADDR: axi_arvalid=1 while remaining beats>0 and inflight<OUTSTANDING; burst size n = min(remaining, BURST_MAX, 4 KB limit per REQ-027); axi_arlen = n-1.
REQ-017 On axi_arvalid&axi_arready: address += n*BPB, remaining -= n, inflight += 1; go to DRAIN when remaining reaches 0.
REQ-018 axi_araddr and axi_arlen SHALL stay stable while axi_arvalid=1 and axi_arready=0.
REQ-019 The inflight counter SHALL decrement on axi_rvalid&axi_rready&axi_rlast; a simultaneous increment and decrement leaves it unchanged.
REQ-020 DRAIN: when inflight==0, go to IDLE; cfg_ready reasserts on the following cycle.
REQ-021 The inflight counter SHALL never exceed OUTSTANDING nor underflow; an rlast arriving with inflight==0 is ignored.
REQ-022 cfg_address is BPB-aligned; the low log2(BPB) address bits SHALL be forced to zero on axi_araddr.
REQ-023 Address arithmetic SHALL wrap modulo 2^AXI_ADDR_WIDTH.
REQ-024 Each accepted request SHALL produce exactly one rd handshake, ordered before its first AR handshake.

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, inflight=0, cfg_ready=0, rd_valid=0, rd_length=0, axi_arvalid=0, axi_araddr=0, axi_arlen=0.
REQ-026 After rst_n deasserts, cfg_ready SHALL be 1 on the first clk edge; a reset mid-transfer abandons all bursts with no further AR issue.

Configuration
REQ-027 Macro AXIS_READ_4K_SPLIT_EN, when defined, additionally limits n so that no burst crosses a 4096-byte boundary: n <= (4096 - addr%4096)/BPB.
REQ-028 Without AXIS_READ_4K_SPLIT_EN, n = min(remaining, BURST_MAX) only.

Verification
REQ-029 addr 0x1000, len 10, rd_ready=1, arready=1 -> rd_length=10, then one AR: araddr 0x1000, arlen 1; idle once rlast is seen.
REQ-030 addr 0x0, len 4092 -> 512 beats issued as 32 ARs, arlen 15, araddr 0x0, 0x200, ..., 0x3E00.
REQ-031 addr 0x0F80, len 64, macro defined -> ARs (0x0F80, arlen 3) then (0x1000, arlen 3); macro undefined -> single AR (0x0F80, arlen 7).
REQ-032 arready=1, no rvalid, len 4092 -> exactly 4 ARs, then arvalid=0; one rlast beat -> exactly one more AR.
REQ-033 len 0 -> no rd_valid and no arvalid; cfg_ready=1 on the next cycle.
REQ-034 rst_n low for one cycle mid-ADDR with arvalid=1 -> arvalid=0 immediately, cfg_ready=1 after release, and a new request runs correctly.
